// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: PC-mux select codes and fetch FSM state encoding shared by the fetch unit and its bench
package fetch_unit_pkg;
    localparam int SEL_PC_WIDTH = 2;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_ADD4 = 2'd0;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JAL  = 2'd1;
    localparam logic [SEL_PC_WIDTH-1:0] SEL_PC_JALR = 2'd2;
    localparam int FETCH_STATE_WIDTH = 3;
    typedef enum logic [FETCH_STATE_WIDTH-1:0] {
        S_RESET = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_HALT  = 3'd4
    } fetch_state_e;
endpackage

// File: rtl/next_pc_gen.sv
// next_pc_gen: combinational next-PC selection (JALR > JAL > taken branch > pc+4) with misalignment flag
module next_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0]       pc,
    input  logic [SEL_PC_WIDTH-1:0] pc_sel,
    input  logic                    br_taken,
    input  logic [31:0]             imm,
    input  logic [31:0]             rs1_data,
    output logic [ADDR_W-1:0]       next_pc,
    output logic                    misaligned
);
    logic [ADDR_W-1:0] imm_a;
    logic [ADDR_W-1:0] rs1_a;
    assign imm_a = ADDR_W'(imm);
    assign rs1_a = ADDR_W'(rs1_data);
    always_comb begin
        next_pc    = (pc_sel == SEL_PC_JALR)              ? (rs1_a + imm_a) & ~ADDR_W'(1) :
                     (pc_sel == SEL_PC_JAL || br_taken)   ? pc + imm_a :
                                                            pc + ADDR_W'(4);
        misaligned = |next_pc[1:0];
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding, non-speculative instruction fetch holding one instruction for decode
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic                    imem_rsp_valid,
    input  logic [31:0]             imem_rsp_data,
    output logic [31:0]             code,
    output logic                    code_valid,
    output logic [ADDR_W-1:0]       pc,
    input  logic                    id_ready,
    input  logic [SEL_PC_WIDTH-1:0] pc_sel,
    input  logic                    br_taken,
    input  logic [31:0]             imm,
    input  logic [31:0]             rs1_data,
    output logic                    fetch_err
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
    logic [31:0]       code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic              misaligned;

    next_pc_gen #(.ADDR_W(ADDR_W)) u_next_pc_gen (
        .pc         (pc_q),
        .pc_sel     (pc_sel),
        .br_taken   (br_taken),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        fetch_err_d  = fetch_err_q;
        case (state_q)
            S_RESET: state_d = S_REQ;
            S_REQ:   state_d = imem_req_ready ? S_WAIT : S_REQ;
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    code_d       = imem_rsp_data;
                    code_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    pc_d         = next_pc;
                    code_valid_d = 1'b0;
                    fetch_err_d  = misaligned;
                    state_d      = misaligned ? S_HALT : S_REQ;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            pc_q         <= RESET_PC;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign code           = code_q;
    assign code_valid     = code_valid_q;
    assign fetch_err      = fetch_err_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a next-PC reference model and memory image
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    imem_req_ready = 1'b0;
    logic                    imem_rsp_valid = 1'b0;
    logic [31:0]             imem_rsp_data = '0;
    logic                    id_ready = 1'b0;
    logic [SEL_PC_WIDTH-1:0] pc_sel = SEL_PC_ADD4;
    logic                    br_taken = 1'b0;
    logic [31:0]             imm = '0;
    logic [31:0]             rs1_data = '0;
    logic                    imem_req_valid, code_valid, fetch_err;
    logic [31:0]             imem_addr, code, pc;
    int                      n_checks = 0;
    int                      n_fail = 0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .code           (code),
        .code_valid     (code_valid),
        .pc             (pc),
        .id_ready       (id_ready),
        .pc_sel         (pc_sel),
        .br_taken       (br_taken),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
    endfunction

    // Target chosen by instruction kind; JALR drops bit 0, everything wraps at 2^32.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [SEL_PC_WIDTH-1:0] sel,
                                             input logic br, input logic [31:0] im, input logic [31:0] rs1);
        longint unsigned t;
        if (sel == SEL_PC_JALR) begin
            t = (longint'(rs1) + longint'(im)) % 64'h1_0000_0000;
            return 32'(t - (t % 2));
        end
        if (sel == SEL_PC_JAL || br) return 32'((longint'(cur) + longint'(im)) % 64'h1_0000_0000);
        return 32'((longint'(cur) + 4) % 64'h1_0000_0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        id_ready = 1'b0;
        br_taken = 1'b0;
        pc_sel = SEL_PC_ADD4;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Serves one request: optional ready stall, accept, response after rsp_delay cycles; ends in the hold state.
    task automatic fetch_one(input int req_stall, input int rsp_delay, output logic [31:0] addr, output logic ok);
        int n = 0;
        ok = 1'b1;
        addr = 'x;
        while (!imem_req_valid && n < 10) begin
            tick();
            n++;
        end
        if (!imem_req_valid) begin
            ok = 1'b0;
            return;
        end
        repeat (req_stall) tick();
        addr = imem_addr;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        repeat (rsp_delay) tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem_word(addr);
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
    endtask

    task automatic consume(input logic [SEL_PC_WIDTH-1:0] sel, input logic br, input logic [31:0] im, input logic [31:0] rs1);
        pc_sel = sel;
        br_taken = br;
        imm = im;
        rs1_data = rs1;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        br_taken = 1'b0;
        pc_sel = SEL_PC_ADD4;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        id_ready = 1'b1;
        tick();
        n_checks++;
        if ({imem_req_valid, code_valid, fetch_err, pc, code} !== {3'b000, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_values: req=%b cv=%b err=%b pc=%h code=%h, expected all zero",
                     imem_req_valid, code_valid, fetch_err, pc, code);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        id_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req_valid=%b, expected 0", imem_req_valid);
        end
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: req_valid=%b addr=%h, expected 1 / 00000000", imem_req_valid, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        logic ok;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            fetch_one(0, 0, a, ok);
            n_checks++;
            if (!ok || a !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h ok=%b, expected %h", i, a, ok, 32'(4 * i));
            end
            n_checks++;
            if (code_valid !== 1'b1 || code !== mem_word(32'(4 * i)) || pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL seq_code%0d: cv=%b code=%h pc=%h, expected 1 %h %h",
                         i, code_valid, code, pc, mem_word(32'(4 * i)), 32'(4 * i));
            end
            if (i < 2) begin
                consume(SEL_PC_ADD4, 1'b0, $urandom, $urandom);
                n_checks++;
                if (code_valid !== 1'b0 || imem_req_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL seq_consume%0d: cv=%b req=%b, expected 0 1", i, code_valid, imem_req_valid);
                end
            end
        end
    endtask

    task automatic test_jal();
        logic [31:0] a;
        logic ok;
        consume(SEL_PC_JAL, 1'b0, 32'h10, $urandom);
        fetch_one(0, 1, a, ok);
        n_checks++;
        if (!ok || a !== 32'h18) begin
            n_fail++;
            $display("FAIL jal_target: got %h ok=%b, expected 00000018", a, ok);
        end
    endtask

    task automatic test_jalr_err();
        logic [31:0] a;
        logic ok;
        int extra = 0;
        consume(SEL_PC_JALR, 1'b0, 32'h3, 32'h101);
        fetch_one(0, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h104 || fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_target: got %h ok=%b err=%b, expected 00000104 err=0", a, ok, fetch_err);
        end
        consume(SEL_PC_JALR, 1'b0, 32'h6, 32'h100);
        n_checks++;
        if (fetch_err !== 1'b1 || code_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_misalign: err=%b cv=%b req=%b, expected 1 0 0", fetch_err, code_valid, imem_req_valid);
        end
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        repeat (6) begin
            imem_rsp_valid = $urandom;
            tick();
            extra += int'(imem_req_valid) + int'(code_valid) + int'(!fetch_err);
        end
        imem_req_ready = 1'b0;
        id_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL halt_quiet: %0d violating cycle-signals in halt, expected 0", extra);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        logic ok;
        apply_reset();
        fetch_one(0, 0, a, ok);
        consume(SEL_PC_JAL, 1'b0, 32'h20, $urandom);
        fetch_one(0, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h20) begin
            n_fail++;
            $display("FAIL br_setup: got %h ok=%b, expected 00000020", a, ok);
        end
        consume(SEL_PC_ADD4, 1'b1, 32'hFFFF_FFF0, $urandom);
        fetch_one(1, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h10) begin
            n_fail++;
            $display("FAIL br_backward: got %h ok=%b, expected 00000010", a, ok);
        end
        consume(SEL_PC_JAL, 1'b1, 32'h8, $urandom);
        fetch_one(0, 2, a, ok);
        n_checks++;
        if (!ok || a !== 32'h18) begin
            n_fail++;
            $display("FAIL br_jal_single: got %h ok=%b, expected 00000018", a, ok);
        end
        consume(SEL_PC_JALR, 1'b1, 32'h0, 32'hFFFF_FFFC);
        fetch_one(0, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'hFFFF_FFFC || code !== mem_word(32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL jalr_over_branch: got %h code=%h ok=%b, expected fffffffc %h", a, code, ok, mem_word(32'hFFFF_FFFC));
        end
        consume(SEL_PC_ADD4, 1'b0, $urandom, $urandom);
        fetch_one(0, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h0 || fetch_err !== 1'b0) begin
            n_fail++;
            $display("FAIL pc_wrap: got %h ok=%b err=%b, expected 00000000 err=0", a, ok, fetch_err);
        end
    endtask

    task automatic test_stalls();
        int bad = 0;
        logic [31:0] c0, p0;
        consume(SEL_PC_ADD4, 1'b0, $urandom, $urandom);
        repeat (4) begin
            imem_req_ready = 1'b0;
            tick();
            bad += int'(imem_req_valid !== 1'b1) + int'(imem_addr !== 32'h4);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL req_stall: %0d unstable cycle-signals, expected 0 (addr=%h)", bad, imem_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        n_checks++;
        if (code_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: cv=%b req=%b, expected 0 0", code_valid, imem_req_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem_word(32'h4);
        tick();
        imem_rsp_valid = 1'b0;
        c0 = code;
        p0 = pc;
        bad = 0;
        repeat (5) begin
            pc_sel = SEL_PC_JAL;
            imm = $urandom;
            imem_rsp_valid = 1'b1;
            imem_rsp_data = $urandom;
            imem_req_ready = 1'b1;
            tick();
            bad += int'(code !== c0) + int'(pc !== p0) + int'(code_valid !== 1'b1) + int'(imem_req_valid !== 1'b0);
        end
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        n_checks++;
        if (bad != 0 || c0 !== mem_word(32'h4) || p0 !== 32'h4) begin
            n_fail++;
            $display("FAIL decode_stall: %0d unstable, held code=%h pc=%h, expected 0 / %h / 00000004", bad, c0, p0, mem_word(32'h4));
        end
        consume(SEL_PC_ADD4, 1'b0, $urandom, $urandom);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] a;
        logic ok;
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, code_valid, fetch_err, pc, code} !== {3'b000, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: req=%b cv=%b err=%b pc=%h code=%h, expected all zero",
                     imem_req_valid, code_valid, fetch_err, pc, code);
        end
        tick();
        rst_n = 1'b1;
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hBAD0_BAD0;
        tick();
        tick();
        imem_rsp_valid = 1'b0;
        n_checks++;
        if (code_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || code !== 32'h0) begin
            n_fail++;
            $display("FAIL spurious_rsp: cv=%b req=%b addr=%h code=%h, expected 0 1 00000000 00000000",
                     code_valid, imem_req_valid, imem_addr, code);
        end
        fetch_one(0, 0, a, ok);
        n_checks++;
        if (!ok || a !== 32'h0 || code !== mem_word(32'h0)) begin
            n_fail++;
            $display("FAIL post_reset_fetch: addr=%h code=%h ok=%b, expected 00000000 %h", a, code, ok, mem_word(32'h0));
        end
    endtask

    task automatic test_random();
        logic [31:0] a, exp_pc, nxt, im, rs1;
        logic [SEL_PC_WIDTH-1:0] sel;
        logic br, ok;
        apply_reset();
        exp_pc = 32'h0;
        for (int i = 0; i < 40; i++) begin
            fetch_one($urandom_range(0, 2), $urandom_range(0, 3), a, ok);
            n_checks++;
            if (!ok || a !== exp_pc || code !== mem_word(exp_pc) || pc !== exp_pc) begin
                n_fail++;
                $display("FAIL rand_fetch%0d: addr=%h pc=%h code=%h ok=%b, expected %h %h", i, a, pc, code, ok, exp_pc, mem_word(exp_pc));
            end
            sel = SEL_PC_WIDTH'($urandom_range(0, 2));
            br = 1'($urandom);
            im = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rs1 = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            nxt = ref_next(exp_pc, sel, br, im, rs1);
            consume(sel, br, im, rs1);
            n_checks++;
            if (fetch_err !== (nxt[1:0] != 2'b00) || pc !== nxt) begin
                n_fail++;
                $display("FAIL rand_next%0d: err=%b pc=%h, expected %b %h", i, fetch_err, pc, nxt[1:0] != 2'b00, nxt);
            end
            if (nxt[1:0] != 2'b00) begin
                apply_reset();
                exp_pc = 32'h0;
            end else begin
                exp_pc = nxt;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jal();
        test_jalr_err();
        test_branch();
        test_stalls();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
